// File: rtl/proc_dispatch_ctrl.sv
// Frame dispatcher between the shared input FIFO and the processing engine.
// It latches the mode, parameter and source tag from the head word, starts
// the engine, and streams one frame through a registered valid/ready stage.
// It then waits for the engine to finish and pulses mstr0_cmplt to the arbiter.
module proc_dispatch_ctrl #(
  parameter int DW          = 32,
  parameter int FRAME_WORDS = 1024,
  parameter int CW          = $clog2(FRAME_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_clr,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rdata,
  input  logic [1:0]    fifo_mode,
  input  logic [7:0]    fifo_proc_val,
  input  logic          fifo_src,
  output logic          eng_start,
  output logic [1:0]    eng_mode,
  output logic [7:0]    eng_proc_val,
  output logic [DW-1:0] eng_data,
  output logic          eng_valid,
  input  logic          eng_ready,
  input  logic          eng_done,
  output logic          mstr0_cmplt,
  output logic          frame_src,
  output logic          hdr_err,
  output logic [15:0]   frame_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CONFIG    = 3'd1;
  localparam logic [2:0] S_STREAM    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [CW-1:0] FW_MAX  = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] FW_LAST = CW'(FRAME_WORDS - 1);

  logic [2:0]    state;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] acc_cnt;
  logic          accept;
  logic          hdr_mismatch;

  // A word leaves the output register when the engine takes it.
  assign accept = (state == S_STREAM) && eng_valid && eng_ready;

  // Mid-frame word whose sideband disagrees with the latched header.
  assign hdr_mismatch = (fifo_mode != eng_mode) || (fifo_src != frame_src);

  // Pop request: discard invalid heads in IDLE, refill the output stage in STREAM.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!soft_clr && !fifo_empty) begin
      case (state)
        S_IDLE:   fifo_rd_en = (fifo_mode == 2'd0);
        S_STREAM: fifo_rd_en = (pop_cnt < FW_MAX) && (!eng_valid || eng_ready);
        default:  fifo_rd_en = 1'b0;
      endcase
    end
  end

  // Frame FSM, header latch, output stage, counters and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pop_cnt      <= '0;
      acc_cnt      <= '0;
      eng_start    <= 1'b0;
      eng_mode     <= 2'd0;
      eng_proc_val <= 8'd0;
      eng_data     <= '0;
      eng_valid    <= 1'b0;
      mstr0_cmplt  <= 1'b0;
      frame_src    <= 1'b0;
      hdr_err      <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      eng_start   <= 1'b0;
      mstr0_cmplt <= 1'b0;
      if (soft_clr) begin
        // Abort: drop the in-flight word, keep the completed-frame count.
        state     <= S_IDLE;
        eng_valid <= 1'b0;
        pop_cnt   <= '0;
        acc_cnt   <= '0;
        hdr_err   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!fifo_empty && (fifo_mode != 2'd0)) begin
              // Header stays in the FIFO; it is popped as the first frame word.
              eng_mode     <= fifo_mode;
              eng_proc_val <= fifo_proc_val;
              frame_src    <= fifo_src;
              pop_cnt      <= '0;
              acc_cnt      <= '0;
              eng_start    <= 1'b1;
              state        <= S_CONFIG;
            end
          end
          S_CONFIG: state <= S_STREAM;
          S_STREAM: begin
            if (fifo_rd_en) begin
              eng_data  <= fifo_rdata;
              eng_valid <= 1'b1;
              pop_cnt   <= pop_cnt + 1'b1;
              if (hdr_mismatch) hdr_err <= 1'b1;
            end else if (accept) begin
              eng_valid <= 1'b0;
            end
            if (accept) begin
              acc_cnt <= acc_cnt + 1'b1;
              if (acc_cnt == FW_LAST) state <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            if (eng_done) begin
              mstr0_cmplt <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
              state       <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_dispatch_ctrl.sv
// Bench for proc_dispatch_ctrl with FRAME_WORDS=4: a queue-based FWFT FIFO
// model, a negedge monitor, a table of frame scenarios, and hand-written
// soft_clr / async reset sequences.
module tb_proc_dispatch_ctrl;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int CW = $clog2(FW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          soft_clr;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] hd_data;
  logic [1:0]    hd_mode;
  logic [7:0]    hd_pv;
  logic          hd_src;
  logic          eng_start;
  logic [1:0]    eng_mode;
  logic [7:0]    eng_proc_val;
  logic [DW-1:0] eng_data;
  logic          eng_valid;
  logic          eng_ready;
  logic          eng_done;
  logic          mstr0_cmplt;
  logic          frame_src;
  logic          hdr_err;
  logic [15:0]   frame_cnt;

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  pv;
    logic        src;
    logic [31:0] data;
  } fw_t;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  pv;
    logic        src;
    int          n_disc;
    bit          toggle;
    int          gap_at;
    int          bad_idx;
    logic [31:0] base;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  fw_t  fq[$];
  int   qsize = 0;
  logic gap = 1'b0;
  logic pop_pend = 1'b0;

  int checks = 0;
  int errors = 0;

  // monitor state
  int          cyc = 0;
  int          start_cnt, start_cyc, first_vld_cyc, cmplt_cnt, cmplt_cyc;
  int          done_cyc, pops_m, last_acc_cyc, viol_empty, viol_stall;
  logic [31:0] recv[$];
  logic        prev_stall = 1'b0;
  logic        prev_clr = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_mode = '0;

  vec_t vecs[6];

  assign fifo_empty = (qsize == 0) || gap;

  proc_dispatch_ctrl #(.DW(DW), .FRAME_WORDS(FW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(hd_data),
    .fifo_mode(hd_mode), .fifo_proc_val(hd_pv), .fifo_src(hd_src),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_proc_val(eng_proc_val),
    .eng_data(eng_data), .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_done(eng_done), .mstr0_cmplt(mstr0_cmplt), .frame_src(frame_src),
    .hdr_err(hdr_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic update_head();
    qsize = fq.size();
    if (qsize > 0) begin
      hd_mode = fq[0].mode;
      hd_pv   = fq[0].pv;
      hd_src  = fq[0].src;
      hd_data = fq[0].data;
    end else begin
      hd_mode = 2'd0;
      hd_pv   = 8'd0;
      hd_src  = 1'b0;
      hd_data = '0;
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [7:0] p, input logic s,
                      input logic [31:0] d);
    fw_t w;
    w.mode = m;
    w.pv   = p;
    w.src  = s;
    w.data = d;
    fq.push_back(w);
    update_head();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    start_cnt     = 0;
    start_cyc     = -1;
    first_vld_cyc = -1;
    cmplt_cnt     = 0;
    cmplt_cyc     = -1;
    done_cyc      = -1;
    pops_m        = 0;
    last_acc_cyc  = -1;
    viol_empty    = 0;
    viol_stall    = 0;
    recv.delete();
  endtask

  // FIFO model: pop the head shortly after the edge the DUT popped on.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fq.size() > 0) fq.delete(0);
      update_head();
    end
  end

  // Monitor: samples everything on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_rd_en && fifo_empty) viol_empty++;
      if (fifo_rd_en) pops_m++;
      pop_pend = fifo_rd_en;
      if (eng_start) begin start_cnt++; start_cyc = cyc; end
      if (eng_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (mstr0_cmplt) begin cmplt_cnt++; cmplt_cyc = cyc; end
      if (eng_done && done_cyc < 0) done_cyc = cyc;
      if (prev_stall && !prev_clr && !rst) begin
        if (!eng_valid || eng_data !== prev_data || eng_mode !== prev_mode) viol_stall++;
      end
      if (eng_valid && eng_ready) begin
        recv.push_back(eng_data);
        if (recv.size() == FW) last_acc_cyc = cyc;
      end
      prev_stall = eng_valid && !eng_ready && !rst;
      prev_data  = eng_data;
      prev_mode  = eng_mode;
      prev_clr   = soft_clr;
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    bit finished = 0;
    int gap_left = 0;
    bit gap_used = 0;
    clr_mon();
    for (int i = 0; i < v.n_disc; i++) push(2'd0, 8'hEE, 1'b0, 32'hDEAD_0000 + i);
    for (int i = 0; i < FW; i++)
      push(v.mode, v.pv, (i == v.bad_idx) ? ~v.src : v.src, v.base + i);
    eng_ready = 1'b1;
    eng_done  = 1'b0;
    gap       = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(posedge clk);
      #1;
      eng_ready = v.toggle ? ~eng_ready : 1'b1;
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) gap = 1'b0;
      end else if (v.gap_at >= 0 && !gap_used && pops_m >= v.n_disc + v.gap_at) begin
        gap      = 1'b1;
        gap_left = 3;
        gap_used = 1;
      end
      if (cmplt_cnt > 0) begin
        eng_done = 1'b0;
        finished = 1;
      end else if (recv.size() == FW && cyc >= last_acc_cyc + 2) begin
        eng_done = 1'b1;
      end
    end
    gap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    eng_ready = 1'b1;
    chk({tag, " finished"}, 32'(finished), 32'd1);
    chk({tag, " start_cnt"}, 32'(start_cnt), 32'd1);
    chk({tag, " start_to_valid"}, 32'(first_vld_cyc - start_cyc), 32'd2);
    chk({tag, " cmplt_cnt"}, 32'(cmplt_cnt), 32'd1);
    chk({tag, " done_to_cmplt"}, 32'(cmplt_cyc - done_cyc), 32'd1);
    chk({tag, " pops"}, 32'(pops_m), 32'(v.n_disc + FW));
    chk({tag, " words"}, 32'(recv.size()), 32'(FW));
    for (int i = 0; i < FW; i++)
      if (i < recv.size()) chk({tag, " word"}, recv[i], v.base + i);
    chk({tag, " eng_mode"}, 32'(eng_mode), 32'(v.mode));
    chk({tag, " eng_proc_val"}, 32'(eng_proc_val), 32'(v.pv));
    chk({tag, " frame_src"}, 32'(frame_src), 32'(v.src));
    chk({tag, " hdr_err"}, 32'(hdr_err), 32'(v.exp_err));
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(v.exp_cnt));
    chk({tag, " pop_while_empty"}, 32'(viol_empty), 32'd0);
    chk({tag, " stall_stable"}, 32'(viol_stall), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          mode   pv     src   disc tog  gap  bad  base         err   cnt
    vecs[0] = '{2'd2, 8'h15, 1'b1, 0, 1'b0, -1, -1, 32'h0000_00A0, 1'b0, 16'd1};
    vecs[1] = '{2'd2, 8'h15, 1'b1, 0, 1'b1,  2, -1, 32'h0000_00A0, 1'b0, 16'd2};
    vecs[2] = '{2'd1, 8'h3C, 1'b0, 2, 1'b0, -1, -1, 32'h0000_00B0, 1'b0, 16'd3};
    vecs[3] = '{2'd2, 8'h15, 1'b1, 0, 1'b0, -1,  2, 32'h0000_00C0, 1'b1, 16'd4};
    vecs[4] = '{2'd1, 8'h5A, 1'b0, 0, 1'b0, -1, -1, 32'h0000_0060, 1'b0, 16'd5};
    vecs[5] = '{2'd3, 8'h81, 1'b1, 1, 1'b1, -1, -1, 32'h0000_0070, 1'b0, 16'd1};

    rst       = 1'b1;
    soft_clr  = 1'b0;
    eng_ready = 1'b0;
    eng_done  = 1'b0;
    update_head();
    clr_mon();
    repeat (2) @(negedge clk);
    chk("rst eng_start", 32'(eng_start), 32'd0);
    chk("rst eng_valid", 32'(eng_valid), 32'd0);
    chk("rst eng_data", eng_data, 32'd0);
    chk("rst mstr0_cmplt", 32'(mstr0_cmplt), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst hdr_err", 32'(hdr_err), 32'd0);
    chk("rst fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // soft_clr after two words of a frame have been accepted
    clr_mon();
    for (int i = 0; i < FW; i++) push(2'd3, 8'h77, 1'b0, 32'h0000_00D0 + i);
    eng_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (recv.size() >= 2) break;
    end
    chk("clr accepted", 32'(recv.size()), 32'd2);
    if (recv.size() >= 2) begin
      chk("clr word0", recv[0], 32'h0000_00D0);
      chk("clr word1", recv[1], 32'h0000_00D1);
    end
    eng_ready = 1'b0;
    soft_clr  = 1'b1;
    fq.delete();
    update_head();
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
    @(negedge clk);
    chk("clr eng_valid", 32'(eng_valid), 32'd0);
    @(posedge clk);
    #1;
    clr_mon();
    eng_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("clr no_cmplt", 32'(cmplt_cnt), 32'd0);
    chk("clr no_start", 32'(start_cnt), 32'd0);
    chk("clr no_pop", 32'(pops_m), 32'd0);
    chk("clr frame_cnt", 32'(frame_cnt), 32'd4);
    chk("clr hdr_err", 32'(hdr_err), 32'd0);
    chk("clr eng_valid_idle", 32'(eng_valid), 32'd0);
    run_vec(vecs[4], "after_clr");

    // asynchronous reset in the middle of a frame
    clr_mon();
    for (int i = 0; i < FW; i++) push(2'd1, 8'h42, 1'b1, 32'h0000_00E0 + i);
    eng_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (recv.size() >= 1) break;
    end
    chk("rstmid started", 32'(eng_valid), 32'd1);
    #2;
    rst = 1'b1;
    fq.delete();
    update_head();
    #1;
    chk("rstmid eng_valid", 32'(eng_valid), 32'd0);
    chk("rstmid eng_data", eng_data, 32'd0);
    chk("rstmid eng_mode", 32'(eng_mode), 32'd0);
    chk("rstmid eng_proc_val", 32'(eng_proc_val), 32'd0);
    chk("rstmid frame_src", 32'(frame_src), 32'd0);
    chk("rstmid frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rstmid eng_start", 32'(eng_start), 32'd0);
    chk("rstmid mstr0_cmplt", 32'(mstr0_cmplt), 32'd0);
    chk("rstmid fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_vec(vecs[5], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
